// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter family.
// rr_next is width-generic up to MAX_REQ so any shared-resource controller can reuse it.
package mem_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 64;
    localparam int MAX_REQ   = 32;

    // Rotate so the search starts just above ptr, take the first set bit, map back.
    function automatic logic [MAX_REQ-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        logic [4:0]         idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n && !found) begin
                idx = 5'((ptr + 1 + i) % n);
                if (req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: one-hot winner and its index, searching upward from ptr_i+1.
module mem_rr_pick
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    logic [MAX_REQ-1:0] full_gnt;

    always_comb begin
        full_gnt = rr_next(MAX_REQ'(req_i), 32'(ptr_i), NUM_REQ);
        idx_o    = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (full_gnt[i]) begin
                idx_o = PTR_W'(i);
            end
        end
    end

    assign gnt_o = full_gnt[NUM_REQ-1:0];
    assign any_o = |req_i;

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port among NUM_REQ requesters,
// with a watchdog that releases the port when memory never answers.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int WIDTH          = DEF_WIDTH,
    parameter  int DEPTH          = DEF_DEPTH,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int ADDR_WIDTH     = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wdata_o,
    input  logic                          mem_ready_i,
    input  logic [WIDTH-1:0]              mem_rdata_i,
    output logic                          timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_any;

    mem_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        req_ready_o = '0;
        req_rdata_o = '0;
        timeout_o   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    gnt_d   = pick_gnt;
                    wr_d    = req_wr_rd_i[pick_idx];
                    addr_d  = req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata_i[pick_idx*WIDTH +: WIDTH];
                    ptr_d   = pick_idx;
                    wd_d    = '0;
                end
            end
            ARB_BUSY: begin
                // A response on the watchdog's last cycle still completes normally.
                if (mem_ready_i) begin
                    req_ready_o = gnt_q;
                    req_rdata_o = mem_rdata_i;
                    state_d     = ARB_IDLE;
                    gnt_d       = '0;
                end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
                    timeout_o = 1'b1;
                    state_d   = ARB_IDLE;
                    gnt_d     = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign mem_valid_o = (state_q == ARB_BUSY);
    assign mem_wr_rd_o = wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios followed by a randomized
// phase checked against a transaction-level round-robin model.
module tb_mem_rr_arbiter;

    localparam int NR = 4;
    localparam int W  = 16;
    localparam int D  = 64;
    localparam int AW = 6;
    localparam int TO = 8;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [NR-1:0]    req_valid_i;
    logic [NR-1:0]    req_wr_rd_i;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR*W-1:0]  req_wdata_i;
    logic [NR-1:0]    req_ready_o;
    logic [W-1:0]     req_rdata_o;
    logic [NR-1:0]    gnt_o;
    logic             mem_valid_o;
    logic             mem_wr_rd_o;
    logic [AW-1:0]    mem_addr_o;
    logic [W-1:0]     mem_wdata_o;
    logic             mem_ready_i;
    logic [W-1:0]     mem_rdata_i;
    logic             timeout_o;

    int total = 0;
    int bad   = 0;

    // Transaction-level model state for the randomized phase
    logic          m_busy;
    int            m_owner;
    int            m_last;
    int            m_wait;
    int            m_lat;
    int            win;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_wdata;
    logic          cur_ready;

    mem_rr_arbiter #(
        .NUM_REQ        (NR),
        .WIDTH          (W),
        .DEPTH          (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_wr_rd_i (req_wr_rd_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .req_rdata_o (req_rdata_o),
        .gnt_o       (gnt_o),
        .mem_valid_o (mem_valid_o),
        .mem_wr_rd_o (mem_wr_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic wr,
                           input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid_i[r]           = v;
        req_wr_rd_i[r]           = wr;
        req_addr_i[r*AW +: AW]   = a;
        req_wdata_i[r*W +: W]    = d;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_gnt"},   32'(gnt_o),       32'h0);
        check_output({tag, "_mval"},  32'(mem_valid_o), 32'h0);
        check_output({tag, "_mwr"},   32'(mem_wr_rd_o), 32'h0);
        check_output({tag, "_maddr"}, 32'(mem_addr_o),  32'h0);
        check_output({tag, "_mwd"},   32'(mem_wdata_o), 32'h0);
        check_output({tag, "_rdy"},   32'(req_ready_o), 32'h0);
        check_output({tag, "_rdat"},  32'(req_rdata_o), 32'h0);
        check_output({tag, "_tmo"},   32'(timeout_o),   32'h0);
    endtask

    initial begin
        reset_i     = 1'b0;
        req_valid_i = '0;
        req_wr_rd_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;

        // Reset and idle: everything quiet
        next_cycle();
        sample();
        check_all_zero("in_reset");
        next_cycle();
        reset_i = 1'b1;
        sample();
        check_all_zero("idle");

        // Single read from requester 2
        next_cycle();
        set_req(2, 1'b1, 1'b0, AW'(5), W'(0));
        sample();
        check_output("rd_idle_mval", 32'(mem_valid_o), 32'h0);
        next_cycle();
        sample();
        check_output("rd_gnt",   32'(gnt_o),       32'h4);
        check_output("rd_mval",  32'(mem_valid_o), 32'h1);
        check_output("rd_maddr", 32'(mem_addr_o),  32'd5);
        check_output("rd_mwr",   32'(mem_wr_rd_o), 32'h0);
        check_output("rd_rdy0",  32'(req_ready_o), 32'h0);
        next_cycle();
        mem_ready_i = 1'b1;
        mem_rdata_i = 16'hBEEF;
        sample();
        check_output("rd_rdy",  32'(req_ready_o), 32'h4);
        check_output("rd_rdat", 32'(req_rdata_o), 32'hBEEF);
        next_cycle();
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        set_req(2, 1'b0, 1'b0, AW'(0), W'(0));
        sample();
        check_output("rd_done_mval", 32'(mem_valid_o), 32'h0);
        check_output("rd_done_gnt",  32'(gnt_o),       32'h0);

        // Write from requester 1 held stable through 5 wait cycles while it changes its inputs
        next_cycle();
        set_req(1, 1'b1, 1'b1, AW'(63), 16'h1234);
        sample();
        for (int w = 0; w < 5; w++) begin
            next_cycle();
            if (w == 2) set_req(1, 1'b1, 1'b0, AW'(10), 16'h5555);
            sample();
            check_output("wr_mval",  32'(mem_valid_o), 32'h1);
            check_output("wr_gnt",   32'(gnt_o),       32'h2);
            check_output("wr_mwr",   32'(mem_wr_rd_o), 32'h1);
            check_output("wr_maddr", 32'(mem_addr_o),  32'd63);
            check_output("wr_mwd",   32'(mem_wdata_o), 32'h1234);
            check_output("wr_rdy0",  32'(req_ready_o), 32'h0);
        end
        next_cycle();
        mem_ready_i = 1'b1;
        sample();
        check_output("wr_rdy", 32'(req_ready_o), 32'h2);
        next_cycle();
        mem_ready_i = 1'b0;
        set_req(1, 1'b0, 1'b0, AW'(0), W'(0));
        sample();
        check_output("wr_done_mval", 32'(mem_valid_o), 32'h0);

        // Watchdog abort on requester 3; requester 0 queues behind it and wins next
        next_cycle();
        set_req(3, 1'b1, 1'b0, AW'(7), W'(0));
        sample();
        for (int b = 1; b <= TO; b++) begin
            next_cycle();
            if (b == 3) set_req(0, 1'b1, 1'b0, AW'(9), W'(0));
            sample();
            check_output("to_mval", 32'(mem_valid_o), 32'h1);
            check_output("to_gnt",  32'(gnt_o),       32'h8);
            check_output("to_rdy",  32'(req_ready_o), 32'h0);
            check_output("to_pulse", 32'(timeout_o), (b == TO) ? 32'h1 : 32'h0);
        end
        next_cycle();
        sample();
        check_output("to_after_tmo",  32'(timeout_o),   32'h0);
        check_output("to_after_mval", 32'(mem_valid_o), 32'h0);
        check_output("to_after_gnt",  32'(gnt_o),       32'h0);
        next_cycle();
        sample();
        check_output("to_next_gnt",   32'(gnt_o),      32'h1);
        check_output("to_next_maddr", 32'(mem_addr_o), 32'd9);
        next_cycle();
        mem_ready_i = 1'b1;
        sample();
        check_output("to_next_rdy", 32'(req_ready_o), 32'h1);
        next_cycle();
        mem_ready_i = 1'b0;
        set_req(0, 1'b0, 1'b0, AW'(0), W'(0));
        set_req(3, 1'b0, 1'b0, AW'(0), W'(0));
        sample();
        check_output("to_idle_mval", 32'(mem_valid_o), 32'h0);

        // Memory answers on exactly the last watchdog cycle: ready wins
        next_cycle();
        set_req(1, 1'b1, 1'b0, AW'(20), W'(0));
        sample();
        for (int b = 1; b <= TO; b++) begin
            next_cycle();
            mem_ready_i = (b == TO);
            mem_rdata_i = 16'h0A0A;
            sample();
            check_output("edge_tmo", 32'(timeout_o), 32'h0);
            check_output("edge_rdy", 32'(req_ready_o), (b == TO) ? 32'h2 : 32'h0);
        end
        next_cycle();
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        set_req(1, 1'b0, 1'b0, AW'(0), W'(0));
        sample();
        check_output("edge_after_tmo",  32'(timeout_o),   32'h0);
        check_output("edge_after_mval", 32'(mem_valid_o), 32'h0);

        // Asynchronous reset in the middle of a transaction
        next_cycle();
        set_req(2, 1'b1, 1'b0, AW'(3), W'(0));
        sample();
        next_cycle();
        sample();
        check_output("ar_pre_gnt", 32'(gnt_o), 32'h4);
        #1;
        reset_i = 1'b0;
        #1;
        check_output("ar_mval",  32'(mem_valid_o), 32'h0);
        check_output("ar_gnt",   32'(gnt_o),       32'h0);
        check_output("ar_maddr", 32'(mem_addr_o),  32'h0);
        next_cycle();
        reset_i = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b0, AW'(40 + r), W'(0));

        // All requesters valid, memory ready at once: grants rotate 0,1,2,3,...
        for (int k = 0; k < 8; k++) begin
            sample();
            check_output("rr_idle_mval", 32'(mem_valid_o), 32'h0);
            check_output("rr_idle_gnt",  32'(gnt_o),       32'h0);
            next_cycle();
            mem_ready_i = 1'b1;
            sample();
            check_output("rr_gnt",   32'(gnt_o),       32'(1 << (k % NR)));
            check_output("rr_rdy",   32'(req_ready_o), 32'(1 << (k % NR)));
            check_output("rr_maddr", 32'(mem_addr_o),  32'(40 + (k % NR)));
            next_cycle();
            mem_ready_i = 1'b0;
        end
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, 1'b0, AW'(0), W'(0));

        // Randomized traffic against the round-robin model; last winner was requester 3
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NR - 1;
        m_wait  = 0;
        m_lat   = 0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            for (int r = 0; r < NR; r++) begin
                set_req(r,
                        (m_busy && r == m_owner) ? 1'b1 : ($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, D - 1)),
                        W'($urandom()));
            end
            cur_ready   = m_busy && (m_wait >= m_lat);
            mem_ready_i = cur_ready;
            mem_rdata_i = W'($urandom());
            sample();
            check_output("rnd_mval", 32'(mem_valid_o), 32'(m_busy));
            check_output("rnd_gnt",  32'(gnt_o), m_busy ? 32'(1 << m_owner) : 32'h0);
            check_output("rnd_rdy",  32'(req_ready_o), cur_ready ? 32'(1 << m_owner) : 32'h0);
            check_output("rnd_tmo",  32'(timeout_o), 32'h0);
            if (m_busy) begin
                check_output("rnd_mwr",   32'(mem_wr_rd_o), 32'(m_wr));
                check_output("rnd_maddr", 32'(mem_addr_o),  32'(m_addr));
                check_output("rnd_mwd",   32'(mem_wdata_o), 32'(m_wdata));
            end
            if (!cur_ready) check_output("rnd_rdat0", 32'(req_rdata_o), 32'h0);
            else if (!m_wr) check_output("rnd_rdat", 32'(req_rdata_o), 32'(mem_rdata_i));

            if (m_busy) begin
                if (cur_ready) m_busy = 1'b0;
                else m_wait++;
            end else begin
                win = -1;
                for (int k = 1; k <= NR; k++) begin
                    if (win < 0 && req_valid_i[(m_last + k) % NR]) win = (m_last + k) % NR;
                end
                if (win >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = win;
                    m_last  = win;
                    m_wr    = req_wr_rd_i[win];
                    m_addr  = req_addr_i[win*AW +: AW];
                    m_wdata = req_wdata_i[win*W +: W];
                    m_wait  = 0;
                    m_lat   = $urandom_range(0, 4);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
